// File: rtl/death_chase_pkg.sv
// Shared types and constants for the death_chase game blocks.
//   FIXED_POINT_MULTIPLIER : sub-pixel resolution of object positions (power of two)
//   SCREEN_WIDTH/HEIGHT    : visible area in pixels
//   coord_t                : signed pixel coordinate pair, [0]=x, [1]=y
//   poop_state_t           : life cycle of one dropping slot
package death_chase_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int SCREEN_WIDTH           = 640;
    localparam int SCREEN_HEIGHT          = 480;

    typedef logic signed [1:0][10:0] coord_t;

    typedef enum logic [1:0] {
        FREE,
        FALLING,
        SPLAT
    } poop_state_t;

endpackage

// File: rtl/poop_slot.sv
// One dropping slot: spawns on alloc_i, falls under gravity once per frame, then
// shows a splat on the ground for SPLAT_FRAMES frames before returning to FREE.
// Ports:
//   clk, resetN       : clock, asynchronous active-low reset
//   alloc_i           : claim this slot (honoured only while FREE)
//   spawn_x_i/_y_i    : spawn position in whole pixels
//   start_of_frame_i  : one-clock frame tick, advances the physics
//   hit_i             : collision with the player (honoured only while FALLING)
//   state_o           : registered slot state
//   coordinate_o      : top-left in pixels (fixed-point truncated)
//   land_pulse_o      : one-clock pulse after landing
//   hit_pulse_o       : one-clock pulse after a player hit
module poop_slot
    import death_chase_pkg::*;
#(
    parameter int FPM          = FIXED_POINT_MULTIPLIER,
    parameter int GRAVITY      = 8,
    parameter int MAX_VY       = 512,
    parameter int GROUND_Y     = 440,
    parameter int POOP_HEIGHT  = 8,
    parameter int SPLAT_FRAMES = 16
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               alloc_i,
    input  logic signed [31:0] spawn_x_i,
    input  logic signed [31:0] spawn_y_i,
    input  logic               start_of_frame_i,
    input  logic               hit_i,
    output poop_state_t        state_o,
    output coord_t             coordinate_o,
    output logic               land_pulse_o,
    output logic               hit_pulse_o
);

    localparam int FpShift = $clog2(FPM);
    localparam logic signed [31:0] YClampFp = (GROUND_Y - POOP_HEIGHT) * FPM;

    poop_state_t        state_q;
    logic signed [31:0] x_fp_q, y_fp_q, vy_q;
    logic signed [31:0] splat_cnt_q;
    logic               land_q, hit_q;

    logic signed [31:0] y_fp_d, vy_sum, vy_d;
    logic               landed;

    // Position advances with the old velocity; velocity saturates at MAX_VY.
    always_comb begin
        y_fp_d = y_fp_q + vy_q;
        vy_sum = vy_q + GRAVITY;
        vy_d   = (vy_sum > MAX_VY) ? MAX_VY : vy_sum;
        landed = ((y_fp_d >>> FpShift) + POOP_HEIGHT) >= GROUND_Y;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= FREE;
            x_fp_q      <= '0;
            y_fp_q      <= '0;
            vy_q        <= '0;
            splat_cnt_q <= '0;
            land_q      <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            land_q <= 1'b0;
            hit_q  <= 1'b0;
            unique case (state_q)
                FREE: begin
                    if (alloc_i) begin
                        x_fp_q  <= spawn_x_i <<< FpShift;
                        y_fp_q  <= spawn_y_i <<< FpShift;
                        vy_q    <= '0;
                        state_q <= FALLING;
                    end
                end
                FALLING: begin
                    // A hit pre-empts any landing evaluated on the same clock.
                    if (hit_i) begin
                        state_q <= FREE;
                        hit_q   <= 1'b1;
                    end else if (start_of_frame_i) begin
                        vy_q <= vy_d;
                        if (landed) begin
                            y_fp_q      <= YClampFp;
                            splat_cnt_q <= SPLAT_FRAMES;
                            state_q     <= SPLAT;
                            land_q      <= 1'b1;
                        end else begin
                            y_fp_q <= y_fp_d;
                        end
                    end
                end
                SPLAT: begin
                    if (start_of_frame_i) begin
                        splat_cnt_q <= splat_cnt_q - 1;
                        if (splat_cnt_q <= 1) begin
                            state_q <= FREE;
                        end
                    end
                end
                default: state_q <= FREE;
            endcase
        end
    end

    assign state_o         = state_q;
    assign coordinate_o[0] = 11'(x_fp_q >>> FpShift);
    assign coordinate_o[1] = 11'(y_fp_q >>> FpShift);
    assign land_pulse_o    = land_q;
    assign hit_pulse_o     = hit_q;

endmodule

// File: rtl/poop_manager.sv
// Receives the bird's drop requests, allocates droppings into a fixed pool of slots
// and reports hits, landings and dropped requests.
// Ports:
//   clk, resetN      : clock, asynchronous active-low reset
//   startOfFrame     : one-clock frame tick
//   deploy_poop      : bird drop flag; one spawn per rising edge
//   bird_coordinate  : bird top-left, [0]=x, [1]=y
//   hit_player       : per-slot collision with the player
//   poop_active      : slot is FALLING or SPLAT
//   poop_splat       : slot is SPLAT
//   poop_coordinate  : per-slot top-left in pixels
//   player_damage    : one-clock pulse after any slot hit the player
//   ground_impact    : one-clock pulse after any slot landed
//   drop_overflow    : one-clock pulse after a deploy found no free slot
module poop_manager
    import death_chase_pkg::*;
#(
    parameter int NUM_SLOTS              = 4,
    parameter int FIXED_POINT_MULTIPLIER = death_chase_pkg::FIXED_POINT_MULTIPLIER,
    parameter int GRAVITY                = 8,
    parameter int MAX_VY                 = 512,
    parameter int GROUND_Y               = 440,
    parameter int POOP_WIDTH             = 8,
    parameter int POOP_HEIGHT            = 8,
    parameter int BIRD_WIDTH             = 32,
    parameter int BIRD_HEIGHT            = 32,
    parameter int SPLAT_FRAMES           = 16
) (
    input  logic                                  clk,
    input  logic                                  resetN,
    input  logic                                  startOfFrame,
    input  logic                                  deploy_poop,
    input  logic signed [1:0][10:0]               bird_coordinate,
    input  logic        [NUM_SLOTS-1:0]           hit_player,
    output logic        [NUM_SLOTS-1:0]           poop_active,
    output logic        [NUM_SLOTS-1:0]           poop_splat,
    output logic signed [NUM_SLOTS-1:0][1:0][10:0] poop_coordinate,
    output logic                                  player_damage,
    output logic                                  ground_impact,
    output logic                                  drop_overflow
);

    logic                 deploy_q;
    logic                 overflow_q;
    logic                 deploy_edge;
    logic [NUM_SLOTS-1:0] free_vec, alloc_vec, land_vec, hit_vec;
    logic                 found;
    logic signed [31:0]   spawn_x, spawn_y;
    poop_state_t          slot_state [NUM_SLOTS];

    assign deploy_edge = deploy_poop & ~deploy_q;
    assign spawn_x = 32'($signed(bird_coordinate[0])) + (BIRD_WIDTH - POOP_WIDTH) / 2;
    assign spawn_y = 32'($signed(bird_coordinate[1])) + BIRD_HEIGHT;

    // Lowest-index FREE slot wins; uses registered state so a slot freed this
    // clock only becomes available on the next one.
    always_comb begin
        alloc_vec = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!found && free_vec[i]) begin
                alloc_vec[i] = deploy_edge;
                found        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            deploy_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            deploy_q   <= deploy_poop;
            overflow_q <= deploy_edge & ~(|free_vec);
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        poop_slot #(
            .FPM          (FIXED_POINT_MULTIPLIER),
            .GRAVITY      (GRAVITY),
            .MAX_VY       (MAX_VY),
            .GROUND_Y     (GROUND_Y),
            .POOP_HEIGHT  (POOP_HEIGHT),
            .SPLAT_FRAMES (SPLAT_FRAMES)
        ) u_slot (
            .clk              (clk),
            .resetN           (resetN),
            .alloc_i          (alloc_vec[i]),
            .spawn_x_i        (spawn_x),
            .spawn_y_i        (spawn_y),
            .start_of_frame_i (startOfFrame),
            .hit_i            (hit_player[i]),
            .state_o          (slot_state[i]),
            .coordinate_o     (poop_coordinate[i]),
            .land_pulse_o     (land_vec[i]),
            .hit_pulse_o      (hit_vec[i])
        );

        assign free_vec[i]    = (slot_state[i] == FREE);
        assign poop_active[i] = (slot_state[i] != FREE);
        assign poop_splat[i]  = (slot_state[i] == SPLAT);
    end

    assign player_damage = |hit_vec;
    assign ground_impact = |land_vec;
    assign drop_overflow = overflow_q;

endmodule

// File: tb/tb_poop_manager.sv
module tb_poop_manager;

    logic                          clk;
    logic                          resetN;
    logic                          startOfFrame;
    logic                          deploy_poop;
    logic signed [1:0][10:0]       bird_coordinate;
    logic        [3:0]             hit_player;
    logic        [3:0]             poop_active;
    logic        [3:0]             poop_splat;
    logic signed [3:0][1:0][10:0]  poop_coordinate;
    logic                          player_damage;
    logic                          ground_impact;
    logic                          drop_overflow;

    int checks = 0;
    int errors = 0;

    poop_manager dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .deploy_poop     (deploy_poop),
        .bird_coordinate (bird_coordinate),
        .hit_player      (hit_player),
        .poop_active     (poop_active),
        .poop_splat      (poop_splat),
        .poop_coordinate (poop_coordinate),
        .player_damage   (player_damage),
        .ground_impact   (ground_impact),
        .drop_overflow   (drop_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_bird(input int x, input int y);
        bird_coordinate[0] = 11'(x);
        bird_coordinate[1] = 11'(y);
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        deploy_poop  = 1'b0;
        hit_player   = '0;
        set_bird(0, 0);
        #3;
        check("reset_active", 32'(poop_active), 32'h0);
        check("reset_coord", 32'(poop_coordinate), 32'h0);
        check("reset_pulses", {29'd0, player_damage, ground_impact, drop_overflow}, 32'h0);
        tick();
        resetN = 1'b1;
        tick();

        // Single spawn from a long-held deploy flag
        set_bird(100, 185);
        deploy_poop = 1'b1;
        tick();
        check("spawn_active", 32'(poop_active), 32'h1);
        check("spawn_x", 32'(poop_coordinate[0][0]), 32'd112);
        check("spawn_y", 32'(poop_coordinate[0][1]), 32'd217);
        repeat (5) tick();
        check("held_one_spawn", 32'(poop_active), 32'h1);
        deploy_poop = 1'b0;
        tick();

        // Gravity trajectory to the ground
        frame();
        check("y_frame1", 32'(poop_coordinate[0][1]), 32'd217);
        frame();
        check("y_frame2", 32'(poop_coordinate[0][1]), 32'd217);
        repeat (57) frame();
        check("no_impact_59", 32'(ground_impact), 32'd0);
        check("no_splat_59", 32'(poop_splat), 32'h0);
        frame();
        check("impact_60", 32'(ground_impact), 32'd1);
        check("splat_60", 32'(poop_splat), 32'h1);
        check("y_clamped", 32'(poop_coordinate[0][1]), 32'd432);
        tick();
        check("impact_one_clk", 32'(ground_impact), 32'd0);
        hit_player = 4'b0001;
        tick();
        hit_player = '0;
        check("splat_hit_no_dmg", 32'(player_damage), 32'd0);
        check("splat_hit_kept", 32'(poop_splat), 32'h1);
        repeat (15) frame();
        check("splat_15_active", 32'(poop_active), 32'h1);
        frame();
        check("splat_16_freed", 32'(poop_active), 32'h0);

        // Fill the pool, then overflow
        repeat (4) begin
            deploy_poop = 1'b1;
            tick();
            deploy_poop = 1'b0;
            tick();
        end
        check("pool_full", 32'(poop_active), 32'hF);
        deploy_poop = 1'b1;
        tick();
        check("overflow_pulse", 32'(drop_overflow), 32'd1);
        check("overflow_no_change", 32'(poop_active), 32'hF);
        deploy_poop = 1'b0;
        tick();
        check("overflow_one_clk", 32'(drop_overflow), 32'd0);

        // Free slot2 with a hit, then reallocate it
        hit_player = 4'b0100;
        tick();
        hit_player = '0;
        check("hit2_damage", 32'(player_damage), 32'd1);
        check("hit2_freed", 32'(poop_active), 32'hB);
        tick();
        check("damage_one_clk", 32'(player_damage), 32'd0);
        set_bird(-5, 10);
        deploy_poop = 1'b1;
        tick();
        deploy_poop = 1'b0;
        check("realloc_slot2", 32'(poop_active), 32'hF);
        check("realloc_x", 32'(poop_coordinate[2][0]), 32'd7);
        check("realloc_y", 32'(poop_coordinate[2][1]), 32'd42);
        tick();

        // Hit slot1 while falling
        hit_player = 4'b0010;
        tick();
        hit_player = '0;
        check("hit1_damage", 32'(player_damage), 32'd1);
        check("hit1_freed", 32'(poop_active), 32'hD);

        // Asynchronous reset mid-flight, deploy held through release
        frame();
        frame();
        check("three_active", 32'(poop_active), 32'hD);
        set_bird(50, 400);
        deploy_poop = 1'b1;
        #2;
        resetN = 1'b0;
        #1;
        check("async_active", 32'(poop_active), 32'h0);
        check("async_coord", 32'(poop_coordinate), 32'h0);
        tick();
        resetN = 1'b1;
        tick();
        check("post_reset_spawn", 32'(poop_active), 32'h1);
        check("post_reset_y", 32'(poop_coordinate[0][1]), 32'd432);
        repeat (3) tick();
        check("post_reset_once", 32'(poop_active), 32'h1);
        deploy_poop = 1'b0;
        tick();

        // Hit and landing on the same clock: hit wins
        startOfFrame = 1'b1;
        hit_player   = 4'b0001;
        tick();
        startOfFrame = 1'b0;
        hit_player   = '0;
        check("tie_damage", 32'(player_damage), 32'd1);
        check("tie_no_impact", 32'(ground_impact), 32'd0);
        check("tie_freed", 32'(poop_active), 32'h0);
        tick();

        // Landing threshold one pixel above the ground line
        set_bird(50, 399);
        deploy_poop = 1'b1;
        tick();
        deploy_poop = 1'b0;
        check("edge_spawn_y", 32'(poop_coordinate[0][1]), 32'd431);
        repeat (4) frame();
        check("edge_no_impact", 32'(ground_impact), 32'd0);
        check("edge_y_431", 32'(poop_coordinate[0][1]), 32'd431);
        frame();
        check("edge_impact", 32'(ground_impact), 32'd1);
        check("edge_splat", 32'(poop_splat), 32'h1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
